key_mode_ctrl: RTL and testbench

KEY_MODE_CTRL -- requirements
Module: key_mode_ctrl

---
 rtl/key_pkg.sv | 26 ++
 rtl/key_debounce.sv | 108 ++++++++++
 rtl/key_mode_ctrl.sv | 68 ++++++
 tb/tb_key_mode_ctrl.sv | 442 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared types and constants for the key/mode controller.
// Optional feature macro: KEY_AUTOREPEAT_EN (held keys re-pulse press).
package key_pkg;

    typedef enum logic [1:0] {
        StUp,
        StConfirmDn,
        StDown,
        StConfirmUp
    } key_state_e;

    localparam int unsigned NUM_KEYS  = 4;
    localparam int unsigned KEY_NEXT  = 0;
    localparam int unsigned KEY_PREV  = 1;
    localparam int unsigned KEY_SPEED = 2;
    localparam int unsigned KEY_PAUSE = 3;
    localparam int unsigned SPEED_W   = 2;

    // Counter width covering the longer of the debounce and repeat windows, never below 1.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Single-key synchronizer and debounce FSM producing a level and a one-cycle press pulse.
// Optional feature macro: KEY_AUTOREPEAT_EN (re-pulse press every REPEAT_CYCLES while held).
module key_debounce
    import key_pkg::*;
#(
    parameter int unsigned DB_CYCLES     = 500000,
    parameter int unsigned REPEAT_CYCLES = 25000000
`ifdef KEY_AUTOREPEAT_EN
    ,
    parameter bit          REPEAT_EN     = 1'b1
`endif
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic level,
    output logic press
);

    localparam int unsigned      CNT_W   = cnt_width(DB_CYCLES, REPEAT_CYCLES);
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);
`ifdef KEY_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);
`endif

    logic [1:0]       sync_q;
    key_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             press_q;
    logic             key_low;

    // Two-flop synchronizer; idles high so a reset looks like a released key.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], key_n};
        end
    end

    assign key_low = ~sync_q[1];

    // Debounce FSM; the counter is shared between confirm windows and the repeat timer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StUp;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            press_q <= 1'b0;
            case (state_q)
                StUp: begin
                    if (key_low) begin
                        state_q <= StConfirmDn;
                        cnt_q   <= '0;
                    end
                end
                StConfirmDn: begin
                    if (!key_low) begin
                        state_q <= StUp;
                        cnt_q   <= '0;
                    end else if (cnt_q == DB_LAST) begin
                        state_q <= StDown;
                        cnt_q   <= '0;
                        press_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StDown: begin
                    if (!key_low) begin
                        state_q <= StConfirmUp;
                        cnt_q   <= '0;
                    end
`ifdef KEY_AUTOREPEAT_EN
                    else if (REPEAT_EN) begin
                        if (cnt_q == REP_LAST) begin
                            cnt_q   <= '0;
                            press_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
`endif
                end
                StConfirmUp: begin
                    if (key_low) begin
                        state_q <= StDown;
                        cnt_q   <= '0;
                    end else if (cnt_q == DB_LAST) begin
                        state_q <= StUp;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= StUp;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign level = (state_q == StDown) || (state_q == StConfirmUp);
    assign press = press_q;

endmodule

// File: rtl/key_mode_ctrl.sv
// Four debounced keys driving marquee mode (next/prev), speed and pause registers.
// Optional feature macro: KEY_AUTOREPEAT_EN (keys 0..2 auto-repeat while held).
module key_mode_ctrl
    import key_pkg::*;
#(
    parameter int unsigned DB_CYCLES     = 500000,
    parameter int unsigned REPEAT_CYCLES = 25000000,
    parameter int unsigned MODE_COUNT    = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [3:0]         key_n,
    output logic [3:0]         level,
    output logic [3:0]         press,
    output logic [2:0]         mode,
    output logic [SPEED_W-1:0] speed,
    output logic               pause
);

    localparam logic [2:0] MODE_LAST = 3'(MODE_COUNT - 1);

    logic [2:0]         mode_q;
    logic [SPEED_W-1:0] speed_q;
    logic               pause_q;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_debounce #(
            .DB_CYCLES     (DB_CYCLES),
            .REPEAT_CYCLES (REPEAT_CYCLES)
`ifdef KEY_AUTOREPEAT_EN
            ,
            .REPEAT_EN     (i != KEY_PAUSE)
`endif
        ) u_key (
            .clk   (clk),
            .reset (reset),
            .key_n (key_n[i]),
            .level (level[i]),
            .press (press[i])
        );
    end

    // Mode/speed/pause registers react one cycle after the press pulse; next+prev together cancel.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_q  <= '0;
            speed_q <= '0;
            pause_q <= 1'b0;
        end else begin
            if (press[KEY_NEXT] && !press[KEY_PREV]) begin
                mode_q <= (mode_q == MODE_LAST) ? 3'd0 : mode_q + 3'd1;
            end else if (press[KEY_PREV] && !press[KEY_NEXT]) begin
                mode_q <= (mode_q == 3'd0) ? MODE_LAST : mode_q - 3'd1;
            end
            if (press[KEY_SPEED]) begin
                speed_q <= speed_q + 1'b1;
            end
            if (press[KEY_PAUSE]) begin
                pause_q <= ~pause_q;
            end
        end
    end

    assign mode  = mode_q;
    assign speed = speed_q;
    assign pause = pause_q;

endmodule

// File: tb/tb_key_mode_ctrl.sv
// Self-checking bench for key_mode_ctrl with short debounce/repeat windows.
// Honours KEY_AUTOREPEAT_EN when choosing expected repeat pulses.
module tb_key_mode_ctrl;

    localparam int unsigned DB  = 8;
    localparam int unsigned REP = 32;
    // Key driven at a negedge with cyc=c shows its press pulse at the negedge with cyc=c+LAT.
    localparam int LAT = int'(DB) + 3;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] key_n;
    logic [3:0] level;
    logic [3:0] press;
    logic [2:0] mode;
    logic [1:0] speed;
    logic       pause;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int         cyc;
        logic [3:0] bits;
    } ev_t;

    ev_t exp_q[$];

    // Observed press pulses, written only by the monitor, consumed by the tests.
    int         obs_cyc  [256];
    logic [3:0] obs_bits [256];
    int         obs_wr = 0;
    int         obs_rd = 0;

    logic [2:0] mode_seq  [3] = '{3'd0, 3'd1, 3'd2};
    logic [1:0] speed_seq [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    key_mode_ctrl #(
        .DB_CYCLES     (DB),
        .REPEAT_CYCLES (REP),
        .MODE_COUNT    (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .key_n (key_n),
        .level (level),
        .press (press),
        .mode  (mode),
        .speed (speed),
        .pause (pause)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset === 1'b1 && press !== 4'b0000) begin
            obs_cyc[obs_wr & 255]  <= cyc;
            obs_bits[obs_wr & 255] <= press;
            obs_wr                 <= obs_wr + 1;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        key_n = 4'hF;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic press_key(input logic [3:0] mask, input int hold);
        ev_t e;
        @(negedge clk);
        key_n  = ~mask;
        e.cyc  = cyc + LAT;
        e.bits = mask;
        exp_q.push_back(e);
        repeat (hold) @(negedge clk);
        key_n = 4'hF;
        repeat (DB + 6) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (level !== 4'b0) begin
            failures++; $display("FAIL reset_level: got %b want 0000", level);
        end
        checks++;
        if (press !== 4'b0) begin
            failures++; $display("FAIL reset_press: got %b want 0000", press);
        end
        checks++;
        if (mode !== 3'd0) begin
            failures++; $display("FAIL reset_mode: got %0d want 0", mode);
        end
        checks++;
        if (speed !== 2'd0) begin
            failures++; $display("FAIL reset_speed: got %0d want 0", speed);
        end
        checks++;
        if (pause !== 1'b0) begin
            failures++; $display("FAIL reset_pause: got %b want 0", pause);
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single();
        ev_t e;
        @(negedge clk);
        key_n  = 4'b1110;
        e.cyc  = cyc + LAT;
        e.bits = 4'b0001;
        exp_q.push_back(e);
        repeat (LAT) @(negedge clk);
        checks++;
        if (press !== 4'b0001) begin
            failures++; $display("FAIL single_press: got %b want 0001", press);
        end
        checks++;
        if (level !== 4'b0001) begin
            failures++; $display("FAIL single_level: got %b want 0001", level);
        end
        checks++;
        if (mode !== 3'd0) begin
            failures++; $display("FAIL single_mode_early: got %0d want 0", mode);
        end
        @(negedge clk);
        checks++;
        if (mode !== 3'd1 || press !== 4'b0) begin
            failures++;
            $display("FAIL single_after: mode=%0d press=%b want mode=1 press=0000", mode, press);
        end
        repeat (20 - LAT - 1) @(negedge clk);
        key_n = 4'hF;
        repeat (DB + 6) @(negedge clk);
        checks++;
        if (level !== 4'b0) begin
            failures++; $display("FAIL single_release: level=%b want 0000", level);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_rd >= obs_wr) begin
                failures++;
                $display("FAIL single_sb: missing pulse, want bits=%b cyc=%0d", e.bits, e.cyc);
            end else begin
                if (obs_cyc[obs_rd & 255] !== e.cyc || obs_bits[obs_rd & 255] !== e.bits) begin
                    failures++;
                    $display("FAIL single_sb: got bits=%b cyc=%0d want bits=%b cyc=%0d",
                             obs_bits[obs_rd & 255], obs_cyc[obs_rd & 255], e.bits, e.cyc);
                end
                obs_rd++;
            end
        end
        checks++;
        if (obs_rd != obs_wr) begin
            failures++;
            $display("FAIL single_extra: %0d unexpected pulse(s), got %b want none",
                     obs_wr - obs_rd, obs_bits[obs_rd & 255]);
            obs_rd = obs_wr;
        end
    endtask

    task automatic test_bounce();
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 6; j++) begin
                @(negedge clk);
                key_n[0] = (j >= 3);
                if (level[0] !== 1'b0) seen = 1'b1;
            end
        end
        key_n = 4'hF;
        repeat (DB + 6) @(negedge clk);
        checks++;
        if (seen !== 1'b0) begin
            failures++; $display("FAIL bounce_level: got level[0] high want always 0");
        end
        checks++;
        if (obs_rd != obs_wr) begin
            failures++;
            $display("FAIL bounce_press: %0d pulse(s), got %b want none",
                     obs_wr - obs_rd, obs_bits[obs_rd & 255]);
            obs_rd = obs_wr;
        end
    endtask

    task automatic test_mode();
        ev_t e;
        do_reset();
        press_key(4'b0010, 14);
        checks++;
        if (mode !== 3'd2) begin
            failures++; $display("FAIL mode_prev_wrap: got %0d want 2", mode);
        end
        for (int i = 0; i < 3; i++) begin
            press_key(4'b0001, 14);
            checks++;
            if (mode !== mode_seq[i]) begin
                failures++; $display("FAIL mode_next_%0d: got %0d want %0d", i, mode, mode_seq[i]);
            end
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_rd >= obs_wr) begin
                failures++;
                $display("FAIL mode_sb: missing pulse, want bits=%b cyc=%0d", e.bits, e.cyc);
            end else begin
                if (obs_cyc[obs_rd & 255] !== e.cyc || obs_bits[obs_rd & 255] !== e.bits) begin
                    failures++;
                    $display("FAIL mode_sb: got bits=%b cyc=%0d want bits=%b cyc=%0d",
                             obs_bits[obs_rd & 255], obs_cyc[obs_rd & 255], e.bits, e.cyc);
                end
                obs_rd++;
            end
        end
        checks++;
        if (obs_rd != obs_wr) begin
            failures++;
            $display("FAIL mode_extra: %0d unexpected pulse(s), got %b want none",
                     obs_wr - obs_rd, obs_bits[obs_rd & 255]);
            obs_rd = obs_wr;
        end
    endtask

    task automatic test_simultaneous();
        ev_t e;
        press_key(4'b0011, 14);
        checks++;
        if (mode !== 3'd2) begin
            failures++; $display("FAIL simul_mode: got %0d want 2", mode);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_rd >= obs_wr) begin
                failures++;
                $display("FAIL simul_sb: missing pulse, want bits=%b cyc=%0d", e.bits, e.cyc);
            end else begin
                if (obs_cyc[obs_rd & 255] !== e.cyc || obs_bits[obs_rd & 255] !== e.bits) begin
                    failures++;
                    $display("FAIL simul_sb: got bits=%b cyc=%0d want bits=%b cyc=%0d",
                             obs_bits[obs_rd & 255], obs_cyc[obs_rd & 255], e.bits, e.cyc);
                end
                obs_rd++;
            end
        end
        checks++;
        if (obs_rd != obs_wr) begin
            failures++;
            $display("FAIL simul_extra: %0d unexpected pulse(s), got %b want none",
                     obs_wr - obs_rd, obs_bits[obs_rd & 255]);
            obs_rd = obs_wr;
        end
    endtask

    task automatic test_speed_pause();
        ev_t e;
        for (int i = 0; i < 5; i++) begin
            press_key(4'b0100, 14);
            checks++;
            if (speed !== speed_seq[i]) begin
                failures++; $display("FAIL speed_%0d: got %0d want %0d", i, speed, speed_seq[i]);
            end
        end
        press_key(4'b1000, 14);
        checks++;
        if (pause !== 1'b1) begin
            failures++; $display("FAIL pause_on: got %b want 1", pause);
        end
        press_key(4'b1000, 14);
        checks++;
        if (pause !== 1'b0) begin
            failures++; $display("FAIL pause_off: got %b want 0", pause);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_rd >= obs_wr) begin
                failures++;
                $display("FAIL speed_sb: missing pulse, want bits=%b cyc=%0d", e.bits, e.cyc);
            end else begin
                if (obs_cyc[obs_rd & 255] !== e.cyc || obs_bits[obs_rd & 255] !== e.bits) begin
                    failures++;
                    $display("FAIL speed_sb: got bits=%b cyc=%0d want bits=%b cyc=%0d",
                             obs_bits[obs_rd & 255], obs_cyc[obs_rd & 255], e.bits, e.cyc);
                end
                obs_rd++;
            end
        end
        checks++;
        if (obs_rd != obs_wr) begin
            failures++;
            $display("FAIL speed_extra: %0d unexpected pulse(s), got %b want none",
                     obs_wr - obs_rd, obs_bits[obs_rd & 255]);
            obs_rd = obs_wr;
        end
    endtask

    task automatic test_autorepeat();
        ev_t        e;
        int         c;
        logic [2:0] want_mode;
        do_reset();
        @(negedge clk);
        key_n = 4'b1110;
        c     = cyc;
        e.bits = 4'b0001;
        e.cyc  = c + LAT;
        exp_q.push_back(e);
`ifdef KEY_AUTOREPEAT_EN
        e.cyc = c + LAT + int'(REP);
        exp_q.push_back(e);
        e.cyc = c + LAT + 2 * int'(REP);
        exp_q.push_back(e);
        want_mode = 3'd0;
`else
        want_mode = 3'd1;
`endif
        repeat (100) @(negedge clk);
        key_n = 4'hF;
        repeat (DB + 6) @(negedge clk);
        checks++;
        if (mode !== want_mode) begin
            failures++; $display("FAIL hold_mode: got %0d want %0d", mode, want_mode);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_rd >= obs_wr) begin
                failures++;
                $display("FAIL hold_sb: missing pulse, want bits=%b cyc=%0d", e.bits, e.cyc);
            end else begin
                if (obs_cyc[obs_rd & 255] !== e.cyc || obs_bits[obs_rd & 255] !== e.bits) begin
                    failures++;
                    $display("FAIL hold_sb: got bits=%b cyc=%0d want bits=%b cyc=%0d",
                             obs_bits[obs_rd & 255], obs_cyc[obs_rd & 255], e.bits, e.cyc);
                end
                obs_rd++;
            end
        end
        checks++;
        if (obs_rd != obs_wr) begin
            failures++;
            $display("FAIL hold_extra: %0d unexpected pulse(s), got %b want none",
                     obs_wr - obs_rd, obs_bits[obs_rd & 255]);
            obs_rd = obs_wr;
        end
    endtask

    task automatic test_reset_mid();
        ev_t e;
        do_reset();
        press_key(4'b0100, 14);
        checks++;
        if (speed !== 2'd1) begin
            failures++; $display("FAIL mid_setup_speed: got %0d want 1", speed);
        end
        // Abort a pending press: reset arrives 5 cycles in, key released with it.
        @(negedge clk);
        key_n = 4'b1110;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        key_n = 4'hF;
        #1;
        checks++;
        if (speed !== 2'd0 || level !== 4'b0 || press !== 4'b0) begin
            failures++;
            $display("FAIL mid_async: speed=%0d level=%b press=%b want 0/0000/0000",
                     speed, level, press);
        end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        checks++;
        if (mode !== 3'd0) begin
            failures++; $display("FAIL mid_mode: got %0d want 0", mode);
        end
        // Key held through reset release is debounced from the release.
        @(negedge clk);
        key_n = 4'b1110;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset  = 1'b1;
        e.cyc  = cyc + LAT;
        e.bits = 4'b0001;
        exp_q.push_back(e);
        repeat (14) @(negedge clk);
        key_n = 4'hF;
        repeat (DB + 6) @(negedge clk);
        checks++;
        if (mode !== 3'd1) begin
            failures++; $display("FAIL held_reset_mode: got %0d want 1", mode);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_rd >= obs_wr) begin
                failures++;
                $display("FAIL mid_sb: missing pulse, want bits=%b cyc=%0d", e.bits, e.cyc);
            end else begin
                if (obs_cyc[obs_rd & 255] !== e.cyc || obs_bits[obs_rd & 255] !== e.bits) begin
                    failures++;
                    $display("FAIL mid_sb: got bits=%b cyc=%0d want bits=%b cyc=%0d",
                             obs_bits[obs_rd & 255], obs_cyc[obs_rd & 255], e.bits, e.cyc);
                end
                obs_rd++;
            end
        end
        checks++;
        if (obs_rd != obs_wr) begin
            failures++;
            $display("FAIL mid_extra: %0d unexpected pulse(s), got %b want none",
                     obs_wr - obs_rd, obs_bits[obs_rd & 255]);
            obs_rd = obs_wr;
        end
    endtask

    initial begin
        reset = 1'b0;
        key_n = 4'hF;
        test_reset();
        test_single();
        test_bounce();
        test_mode();
        test_simultaneous();
        test_speed_pause();
        test_autorepeat();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
